legv8_mc_core: RTL and testbench
================================

Name: legv8_mc_core

Overview:
- Multi-cycle LEGv8 subset core. Parametrised successor to the single-cycle CPU.
- Data width and PC/address widths are parameters.
- Instruction and data memories sit behind req/ack handshakes, so wait-state RAMs are supported.
- Adds CBNZ and a clean illegal-instruction halt in place of simulation abort.
- Sits between ins_RAM-class and data_RAM-class memories at SoC top level.

Parameters:
DATA_W, 64, register/ALU/data-bus width (32 or 64)
PC_W, 8, instruction word-address width; PC counts 32-bit words
ADDR_W, 16, data byte-address width driven on dmem_addr
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  word address of fetch (= PC)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
dmem_addr  out  ADDR_W  byte address, low ADDR_W bits of Xn+simm9
dmem_wdata  out  DATA_W  store data (Xt)
dmem_ack  in  1  access complete; dmem_rdata valid this cycle for loads
dmem_rdata  in  DATA_W  load data
pc  out  PC_W  current PC
halted  out  1  core stopped in HALT
illegal  out  1  halt cause was an undecodable instruction
instret  out  32  retired-instruction count (see optional feature)

Behaviour:
- Reset:
  - clk, reset: synchronous, active-high reset; clock clk.
  - On reset: PC=RESET_PC; all 31 GPRs=0; state=FETCH.
  - Outputs: imem_req=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, halted=0, illegal=0, instret=0.
  - Reset mid-transaction aborts it; req is low the cycle after the reset edge; any late ack is ignored.
- Register 31 (XZR): reads 0; writes discarded.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: imem_req=1, imem_addr=PC. On imem_ack, latch IR, go DECODE.
  - DECODE: read Xn, Xm/Xt into operand regs; sign-extend immediate; classify.
    - Unknown encoding -> HALT with illegal=1.
    - Recognised encodings: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, CBZ 10110100, CBNZ 10110101, B 000101.
  - EXEC:
    - R-type: ALU result -> WB.
    - LDUR/STUR: addr=Xn+sext(IR[20:12]) -> MEM.
    - CBZ/CBNZ: test Xt (IR[4:0]) ==0 / !=0. Taken: PC+=sext(IR[23:5]). Else PC+=1. -> FETCH.
    - B: PC+=sext(IR[25:0]) -> FETCH.
  - MEM: dmem_req=1 with dmem_we, addr, wdata held stable until dmem_ack is sampled high.
    - STUR: on ack, PC+=1 -> FETCH.
    - LDUR: on ack, latch rdata -> WB.
  - WB: write Rd (IR[4:0]) with ALU result or load data; PC+=1 -> FETCH.
  - HALT: terminal until reset; halted=1; no requests issued.
- Handshake:
  - At most one outstanding request per port.
  - Ack is accepted in the same cycle req rises (zero-wait).
  - req drops the cycle after ack.
  - Ack while req=0 is ignored.
- Latency with zero-wait memory:
  - R-type 4 cycles; LDUR 5; STUR 4; CBZ/CBNZ/B 3.
  - Each wait cycle adds 1.
- Arithmetic:
  - ALU is modulo 2^DATA_W; no flags.
  - PC arithmetic is modulo 2^PC_W; branch offsets are truncated to PC_W after sign extension, so wrap-around is legal.
  - For DATA_W=32, operands use the low 32 bits.

Optional Feature:
LEGV8_INSTRET_EN
- Defined: instret increments by 1 on every retirement: WB exit, STUR ack, or branch EXEC exit. It wraps at 2^32. It does not count illegal instructions or HALT.
- Undefined: instret is tied to 0 and no counter is synthesised.

Test Plan:
- Reset, zero-wait memory; program ADD X1,XZR,XZR then B 0 -> imem_addr sequence 0,1,1; ADD retires on cycle 4, PC=1 at cycle 5; B at PC=1 with offset 0 loops to PC=1; halted stays 0.
- X2=5, X3=7 (via preloaded LDURs); SUB X4,X2,X3 -> X4=0xFFFF_FFFF_FFFF_FFFE; AND gives 5, ORR gives 7.
- STUR X4,[X2,#-8] with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles; dmem_addr=0xFFFD (ADDR_W=16); dmem_we=1; wdata stable throughout.
- CBZ X5,#-2 at PC=0 with X5=0 -> PC=0xFE (PC_W=8). Same with X5=1 -> PC=1. CBNZ gives the inverse outcomes.
- Instruction 0x00000000 at PC=3 -> halted=1, illegal=1, pc=3; no further imem_req; reset restores PC=0 and illegal=0.
- Assert reset while dmem_req is pending for LDUR -> dmem_req=0 next cycle; destination register unchanged (0); with LEGV8_INSTRET_EN defined, instret=0 after reset.

Source files
------------

// File: rtl/legv8_mc_core.sv
// Multi-cycle LEGv8 subset core (ADD/SUB/AND/ORR/LDUR/STUR/CBZ/CBNZ/B) with req/ack memory ports.
// Optional retired-instruction counter enabled by defining LEGV8_INSTRET_EN.
module legv8_mc_core #(
  parameter int DATA_W   = 64,
  parameter int PC_W     = 8,
  parameter int ADDR_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              illegal,
  output logic [31:0]       instret
);

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ, OP_CBNZ, OP_B
  } op_t;

  state_t              state;
  op_t                 op;
  op_t                 dec_op;
  logic                dec_ok;
  logic                dec_rtype;
  logic [31:0]         ir;
  logic [DATA_W-1:0]   rf [32];
  logic [DATA_W-1:0]   op_a, op_b, imm, result, alu;
  logic [DATA_W-1:0]   imm9, addr_sum;
  logic [PC_W-1:0]     cb_off, b_off;

  // op2 bits of the D-format are not decoded
  logic unused_bits;
  assign unused_bits = &{1'b0, ir[11:10]};

  assign imem_addr = pc;
  assign imm9      = DATA_W'($signed(ir[20:12]));
  assign cb_off    = PC_W'($signed(ir[23:5]));
  assign b_off     = PC_W'($signed(ir[25:0]));
  assign addr_sum  = op_a + imm;

  function automatic logic [DATA_W-1:0] xr(input logic [4:0] idx);
    return (idx == 5'd31) ? '0 : rf[idx];
  endfunction

  always_comb begin
    dec_ok = 1'b1;
    dec_op = OP_ADD;
    if (ir[31:26] == 6'b000101)        dec_op = OP_B;
    else if (ir[31:24] == 8'b10110100) dec_op = OP_CBZ;
    else if (ir[31:24] == 8'b10110101) dec_op = OP_CBNZ;
    else begin
      case (ir[31:21])
        OPC_ADD:  dec_op = OP_ADD;
        OPC_SUB:  dec_op = OP_SUB;
        OPC_AND:  dec_op = OP_AND;
        OPC_ORR:  dec_op = OP_ORR;
        OPC_LDUR: dec_op = OP_LDUR;
        OPC_STUR: dec_op = OP_STUR;
        default:  dec_ok = 1'b0;
      endcase
    end
  end

  assign dec_rtype = (dec_op == OP_ADD) || (dec_op == OP_SUB) ||
                     (dec_op == OP_AND) || (dec_op == OP_ORR);

  always_comb begin
    case (op)
      OP_SUB:  alu = op_a - op_b;
      OP_AND:  alu = op_a & op_b;
      OP_ORR:  alu = op_a | op_b;
      default: alu = op_a + op_b;
    endcase
  end

  // Requests are registered and raised on entry to FETCH/MEM, so the first
  // FETCH after reset spends one idle cycle before imem_req goes high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      op         <= OP_ADD;
      pc         <= PC_W'(RESET_PC);
      ir         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      imm        <= '0;
      result     <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_req && imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        DECODE: begin
          op   <= dec_op;
          op_a <= xr(ir[9:5]);
          op_b <= xr(dec_rtype ? ir[20:16] : ir[4:0]);
          imm  <= imm9;
          if (!dec_ok) begin
            halted  <= 1'b1;
            illegal <= 1'b1;
            state   <= HALT;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          case (op)
            OP_LDUR, OP_STUR: begin
              dmem_req   <= 1'b1;
              dmem_we    <= (op == OP_STUR);
              dmem_addr  <= ADDR_W'(addr_sum);
              dmem_wdata <= op_b;
              state      <= MEM;
            end
            OP_CBZ: begin
              pc       <= pc + ((op_b == '0) ? cb_off : PC_W'(1));
              imem_req <= 1'b1;
              state    <= FETCH;
            end
            OP_CBNZ: begin
              pc       <= pc + ((op_b != '0) ? cb_off : PC_W'(1));
              imem_req <= 1'b1;
              state    <= FETCH;
            end
            OP_B: begin
              pc       <= pc + b_off;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
            default: begin
              result <= alu;
              state  <= WB;
            end
          endcase
        end
        MEM: begin
          if (dmem_req && dmem_ack) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              pc       <= pc + PC_W'(1);
              imem_req <= 1'b1;
              state    <= FETCH;
            end else begin
              result <= dmem_rdata;
              state  <= WB;
            end
          end
        end
        WB: begin
          if (ir[4:0] != 5'd31) rf[ir[4:0]] <= result;
          pc       <= pc + PC_W'(1);
          imem_req <= 1'b1;
          state    <= FETCH;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

`ifdef LEGV8_INSTRET_EN
  logic        retire;
  logic [31:0] instret_q;

  assign retire = (state == WB) ||
                  (state == MEM && dmem_req && dmem_ack && dmem_we) ||
                  (state == EXEC && (op == OP_CBZ || op == OP_CBNZ || op == OP_B));

  always_ff @(posedge clk) begin
    if (reset)       instret_q <= '0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_legv8_mc_core.sv
// Bench for legv8_mc_core: directed scenarios plus random programs checked
// against an instruction-level interpreter; memories respond with wait states.
module tb_legv8_mc_core;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] AND_ = 11'b10001010000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [7:0]  CBZ  = 8'b10110100;
  localparam logic [7:0]  CBNZ = 8'b10110101;
`ifdef LEGV8_INSTRET_EN
  localparam bit IR_EN = 1'b1;
`else
  localparam bit IR_EN = 1'b0;
`endif

  logic        clk, reset;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr, pc;
  logic [31:0] imem_rdata, instret;
  logic        dmem_req, dmem_we, dmem_ack, halted, illegal;
  logic [15:0] dmem_addr;
  logic [63:0] dmem_wdata, dmem_rdata;

  legv8_mc_core dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .halted(halted), .illegal(illegal), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic        we;
    logic [63:0] wdata;
    bit          stable;
  } dtx_t;

  logic [31:0] imem  [256];
  logic [63:0] dram  [65536];
  logic [63:0] mdram [65536];
  logic [7:0]  fetch_q[$];
  dtx_t        dtx_q[$];
  int          mst_q[$];
  int          checks = 0, errors = 0;
  int          i_wmin = 0, i_wmax = 0, d_wmin = 0, d_wmax = 0;
  bit          junk = 1'b0;
  int          iw_cnt = 0, dw_cnt = 0, d_cyc = 0, unstable_cnt = 0;
  dtx_t        cur;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responders: decide ack away from the sampling edge
  always @(negedge clk) begin
    if (imem_req) begin
      if (iw_cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = imem[imem_addr];
        fetch_q.push_back(imem_addr);
      end else begin
        imem_ack = 1'b0;
        iw_cnt--;
      end
    end else begin
      iw_cnt     = $urandom_range(i_wmax, i_wmin);
      imem_ack   = junk & $urandom_range(1, 0);
      imem_rdata = $urandom;
    end
    if (dmem_req) begin
      if (d_cyc == 0) begin
        cur.addr = dmem_addr; cur.we = dmem_we; cur.wdata = dmem_wdata; cur.stable = 1'b1;
      end else if (dmem_addr !== cur.addr || dmem_we !== cur.we || dmem_wdata !== cur.wdata) begin
        cur.stable = 1'b0;
        unstable_cnt++;
      end
      d_cyc++;
      if (dw_cnt == 0) begin
        dmem_ack = 1'b1;
        if (dmem_we) dram[dmem_addr] = dmem_wdata;
        else dmem_rdata = dram[dmem_addr];
        cur.cyc = d_cyc;
        dtx_q.push_back(cur);
      end else begin
        dmem_ack = 1'b0;
        dw_cnt--;
      end
    end else begin
      d_cyc      = 0;
      dw_cnt     = $urandom_range(d_wmax, d_wmin);
      dmem_ack   = junk & $urandom_range(1, 0);
      dmem_rdata = {$urandom, $urandom};
    end
  end

  function automatic logic [31:0] enc_r(input logic [10:0] o, input int rm, input int rn, input int rd);
    logic [4:0] m, n, d;
    m = rm[4:0]; n = rn[4:0]; d = rd[4:0];
    return {o, m, 6'd0, n, d};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] o, input int imm, input int rn, input int rt);
    logic [8:0] i9; logic [4:0] n, t;
    i9 = imm[8:0]; n = rn[4:0]; t = rt[4:0];
    return {o, i9, 2'b00, n, t};
  endfunction
  function automatic logic [31:0] enc_cb(input logic [7:0] o, input int off, input int rt);
    logic [18:0] f; logic [4:0] t;
    f = off[18:0]; t = rt[4:0];
    return {o, f, t};
  endfunction
  function automatic logic [31:0] enc_b(input int off);
    logic [25:0] f;
    f = off[25:0];
    return {6'b000101, f};
  endfunction

  function automatic logic [63:0] init_val(input int a);
    logic [15:0] x;
    x = a[15:0];
    return {x ^ 16'hC0DE, x * 16'd40503, ~x, x ^ 16'h5A5A};
  endfunction

  task automatic init_mem();
    for (int a = 0; a < 65536; a++) begin
      dram[a]  = init_val(a);
      mdram[a] = dram[a];
    end
  endtask

  task automatic clear_imem();
    for (int a = 0; a < 256; a++) imem[a] = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    fetch_q.delete();
    dtx_q.delete();
    unstable_cnt = 0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_to_halt(input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", halted, 1);
  endtask

  function automatic int fq(input int i);
    return (i < fetch_q.size()) ? int'(fetch_q[i]) : -1;
  endfunction

  // Instruction-level interpreter over imem/mdram starting from a fresh reset
  task automatic model_run(output int end_pc, output int nret);
    logic [63:0] r [32];
    logic [63:0] a, b, t;
    logic [31:0] w;
    logic [15:0] ea;
    longint      off;
    int          p, rd;
    p = 0; nret = 0; end_pc = -1;
    mst_q.delete();
    for (int i = 0; i < 32; i++) r[i] = 64'd0;
    for (int step = 0; step < 2000; step++) begin
      w  = imem[p];
      rd = int'(w[4:0]);
      a  = (w[9:5] == 5'd31) ? 64'd0 : r[w[9:5]];
      b  = (w[20:16] == 5'd31) ? 64'd0 : r[w[20:16]];
      t  = (rd == 31) ? 64'd0 : r[rd];
      if (w[31:26] == 6'b000101) begin
        off = longint'($signed(w[25:0]));
        p = int'((p + off) & 255);
        nret++;
      end else if (w[31:24] == CBZ || w[31:24] == CBNZ) begin
        off = longint'($signed(w[23:5]));
        if ((t == 0) == (w[31:24] == CBZ)) p = int'((p + off) & 255);
        else p = (p + 1) & 255;
        nret++;
      end else if (w[31:21] == ADD || w[31:21] == SUB || w[31:21] == AND_ || w[31:21] == ORR) begin
        if (rd != 31) begin
          if (w[31:21] == ADD)      r[rd] = a + b;
          else if (w[31:21] == SUB) r[rd] = a - b;
          else if (w[31:21] == AND_) r[rd] = a & b;
          else                      r[rd] = a | b;
        end
        p = (p + 1) & 255;
        nret++;
      end else if (w[31:21] == LDUR || w[31:21] == STUR) begin
        off = longint'($signed(w[20:12]));
        ea  = 16'(a + 64'(off));
        if (w[31:21] == STUR) begin
          mdram[ea] = t;
          mst_q.push_back(int'(ea));
        end else if (rd != 31) begin
          r[rd] = mdram[ea];
        end
        p = (p + 1) & 255;
        nret++;
      end else begin
        end_pc = p;
        return;
      end
    end
  endtask

  function automatic int rreg();
    int v;
    v = $urandom_range(8, 0);
    return (v == 8) ? 31 : v;
  endfunction

  task automatic gen_prog();
    int k;
    clear_imem();
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(7, 0);
      case (k)
        0: imem[i] = enc_r(ADD,  rreg(), rreg(), rreg());
        1: imem[i] = enc_r(SUB,  rreg(), rreg(), rreg());
        2: imem[i] = enc_r(AND_, rreg(), rreg(), rreg());
        3: imem[i] = enc_r(ORR,  rreg(), rreg(), rreg());
        4: imem[i] = enc_d(LDUR, int'($urandom_range(511, 0)) - 256, rreg(), rreg());
        5: imem[i] = enc_d(STUR, int'($urandom_range(511, 0)) - 256, rreg(), rreg());
        6: imem[i] = (i < 36) ? enc_cb($urandom_range(1, 0) ? CBZ : CBNZ, $urandom_range(3, 1), rreg())
                              : enc_r(ADD, rreg(), rreg(), rreg());
        default: imem[i] = (i < 36) ? enc_b($urandom_range(3, 1)) : enc_r(ORR, rreg(), rreg(), rreg());
      endcase
    end
    for (int k2 = 0; k2 < 8; k2++) imem[40 + k2] = enc_d(STUR, 8 * k2, 31, k2);
  endtask

  initial begin
    int n, mpc, mret;
    reset = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    init_mem();

    // ADD X1,XZR,XZR ; B 0  -- reset state and zero-wait timing
    clear_imem();
    imem[0] = enc_r(ADD, 31, 31, 1);
    imem[1] = enc_b(0);
    do_reset();
    @(negedge clk);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_instret", instret, 0);
    repeat (4) @(negedge clk);
    chk("add_pc_cycle4", pc, 0);
    @(negedge clk);
    chk("add_pc_cycle5", pc, 1);
    chk("add_instret", instret, IR_EN ? 1 : 0);
    repeat (20) @(negedge clk);
    chk("fetch0", fq(0), 0);
    chk("fetch1", fq(1), 1);
    chk("fetch2", fq(2), 1);
    chk("b_loop_pc", pc, 1);
    chk("b_loop_halted", halted, 0);

    // ALU ops on loaded values, then a 3-wait-state store at a negative offset
    clear_imem();
    dram[16'h40] = 64'd5;
    dram[16'h48] = 64'd7;
    imem[0] = enc_d(LDUR, 'h40, 31, 2);
    imem[1] = enc_d(LDUR, 'h48, 31, 3);
    imem[2] = enc_r(SUB, 3, 2, 4);
    imem[3] = enc_r(AND_, 3, 2, 5);
    imem[4] = enc_r(ORR, 3, 2, 6);
    imem[5] = enc_d(STUR, 'h10, 31, 4);
    imem[6] = enc_d(STUR, 'h18, 31, 5);
    imem[7] = enc_d(STUR, 'h20, 31, 6);
    imem[8] = enc_d(STUR, -8, 2, 4);
    d_wmin = 3; d_wmax = 3;
    do_reset();
    run_to_halt(500);
    chk("sub_result", dram[16'h10], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("and_result", dram[16'h18], 64'd5);
    chk("orr_result", dram[16'h20], 64'd7);
    chk("stur_neg_mem", dram[16'hFFFD], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("dtx_count", dtx_q.size(), 6);
    if (dtx_q.size() == 6) begin
      chk("stur_req_cycles", dtx_q[5].cyc, 4);
      chk("stur_addr", dtx_q[5].addr, 16'hFFFD);
      chk("stur_we", dtx_q[5].we, 1);
      chk("stur_wdata", dtx_q[5].wdata, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("stur_stable", dtx_q[5].stable, 1);
    end
    chk("alu_halt_pc", pc, 9);
    chk("alu_instret", instret, IR_EN ? 9 : 0);
    d_wmin = 0; d_wmax = 0;

    // CBZ X5,#-2 at PC=0: taken to 0xFE, then wraps back with X5=1 and falls through
    clear_imem();
    dram[16'h40] = 64'd1;
    imem[0]    = enc_cb(CBZ, -2, 5);
    imem[8'hFE] = enc_d(LDUR, 'h40, 31, 5);
    imem[8'hFF] = enc_b(1);
    do_reset();
    run_to_halt(200);
    chk("cbz_taken_fetch", fq(1), 8'hFE);
    chk("b_wrap_fetch", fq(3), 0);
    chk("cbz_not_taken_fetch", fq(4), 1);
    chk("cbz_halt_pc", pc, 1);
    chk("cbz_instret", instret, IR_EN ? 4 : 0);

    // CBNZ with X5=0 falls through
    imem[0] = enc_cb(CBNZ, -2, 5);
    do_reset();
    run_to_halt(200);
    chk("cbnz_zero_fetch", fq(1), 1);
    chk("cbnz_zero_pc", pc, 1);

    // CBNZ with X5=1 is taken backwards with wrap
    clear_imem();
    imem[0] = enc_d(LDUR, 'h40, 31, 5);
    imem[1] = enc_cb(CBNZ, -3, 5);
    do_reset();
    run_to_halt(200);
    chk("cbnz_taken_pc", pc, 8'hFE);
    chk("cbnz_instret", instret, IR_EN ? 2 : 0);

    // Illegal instruction at PC=3
    clear_imem();
    imem[0] = enc_r(ADD, 1, 1, 1);
    imem[1] = enc_r(SUB, 2, 1, 3);
    imem[2] = enc_r(ORR, 3, 2, 4);
    do_reset();
    run_to_halt(200);
    chk("ill_illegal", illegal, 1);
    chk("ill_pc", pc, 3);
    junk = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req || dmem_req) n++;
    end
    chk("ill_no_req", n, 0);
    chk("ill_still_halted", halted, 1);
    junk = 1'b0;
    do_reset();
    @(negedge clk);
    chk("ill_rst_pc", pc, 0);
    chk("ill_rst_illegal", illegal, 0);
    chk("ill_rst_halted", halted, 0);

    // Reset while a load is waiting on dmem_ack
    clear_imem();
    dram[16'h8] = 64'h1234_5678;
    imem[0] = enc_d(LDUR, 8, 31, 7);
    d_wmin = 50; d_wmax = 50;
    do_reset();
    n = 0;
    while (!dmem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ld_pending", dmem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_dmem_req", dmem_req, 0);
    chk("abort_imem_req", imem_req, 0);
    chk("abort_instret", instret, 0);
    imem[0] = enc_d(STUR, 'h30, 31, 7);
    dram[16'h30] = 64'hDEAD_BEEF;
    d_wmin = 0; d_wmax = 0;
    do_reset();
    run_to_halt(200);
    chk("abort_x7_zero", dram[16'h30], 0);
    chk("abort_halt_pc", pc, 1);

    // Random programs with random wait states and stray acks
    for (int it = 0; it < 3; it++) begin
      init_mem();
      gen_prog();
      i_wmin = 0; i_wmax = 3; d_wmin = 0; d_wmax = 3;
      junk = 1'b1;
      model_run(mpc, mret);
      do_reset();
      run_to_halt(5000);
      chk("rnd_pc", pc, mpc);
      chk("rnd_illegal", illegal, 1);
      chk("rnd_instret", instret, IR_EN ? mret : 0);
      chk("rnd_dmem_stable", unstable_cnt, 0);
      for (int k = 0; k < 8; k++) chk("rnd_dump_reg", dram[8 * k], mdram[8 * k]);
      foreach (mst_q[j]) chk("rnd_store", dram[mst_q[j]], mdram[mst_q[j]]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
